// File: rtl/multi_cycle_add_sub.sv
// Wide adder-subtractor: one CHUNK-bit slice per cycle through a single
// ripple-carry adder, carry registered between slices, valid/ready on both sides.
module multi_cycle_add_sub #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (((WIDTH % CHUNK) != 0) || (CHUNK < 2)) begin : g_param_check
    $error("multi_cycle_add_sub: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic               sub_q, sub_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d, v_q, v_d, zero_q, zero_d;
  logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic [CHUNK-1:0]   a_c, yc_c, b_c, s_c;
  logic               ci_c, co_c, v_c;

  // Select the active slice; subtract is done as x + ~y + 1 via the first carry-in.
  always_comb begin
    a_c  = '0;
    yc_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_c  = x_q[i*CHUNK +: CHUNK];
        yc_c = y_q[i*CHUNK +: CHUNK];
      end
    end
    b_c  = yc_c ^ {CHUNK{sub_q}};
    ci_c = (k_q == '0) ? sub_q : carry_q;
  end

  // Adder's own sub input stays low: it would force carry-in on every slice.
  rippleCarryAddSubP #(.M(CHUNK)) u_add (
    .a   (a_c),
    .b   (b_c),
    .ci  (ci_c),
    .sub (1'b0),
    .s   (s_c),
    .co  (co_c),
    .v   (v_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    x_d         = x_q;
    y_d         = y_q;
    sub_d       = sub_q;
    result_d    = result_q;
    cout_d      = cout_q;
    v_d         = v_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = x;
          y_d        = y;
          sub_d      = sub;
          k_d        = '0;
          carry_d    = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (k_q == KW'(i)) result_d[i*CHUNK +: CHUNK] = s_c;
        end
        carry_d = co_c;
        if (k_q == K_LAST) begin
          cout_d      = co_c;
          v_d         = v_c;
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign v         = v_q;
  assign zero      = zero_q;

endmodule

// M-bit ripple-carry adder-subtractor; sub inverts b and forces carry-in high.
module rippleCarryAddSubP #(
  parameter int unsigned M = 16
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic [M-1:0] s,
  output logic         co,
  output logic         v
);

  logic [M:0]   c;
  logic [M-1:0] bb;

  // Bit-serial carry chain; overflow is carry into MSB xor carry out of MSB.
  always_comb begin
    bb   = b ^ {M{sub}};
    s    = '0;
    c    = '0;
    c[0] = ci | sub;
    for (int unsigned i = 0; i < M; i++) begin
      s[i]   = a[i] ^ bb[i] ^ c[i];
      c[i+1] = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
    end
    co = c[M];
    v  = c[M] ^ c[M-1];
  end

endmodule

// File: tb/tb_multi_cycle_add_sub.sv
// Scoreboard bench: three instances (CHUNK=16, 8, 64) checked against a
// full-width arithmetic model, including handshake latency.
module tb_multi_cycle_add_sub;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_a [3];
  logic        in_ready_a [3];
  logic        sub_a      [3];
  logic [63:0] x_a        [3];
  logic [63:0] y_a        [3];
  logic        out_valid_a[3];
  logic        out_ready_a[3];
  logic [63:0] result_a   [3];
  logic        cout_a     [3];
  logic        v_a        [3];
  logic        zero_a     [3];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned left_a[3];
  bit          rnd_phase = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic s);
    exp_t e;
    logic [64:0] f;
    if (!s) begin
      f   = {1'b0, a} + {1'b0, b};
      e.c = f[64];
      e.v = (a[63] == b[63]) && (f[63] != a[63]);
    end else begin
      f   = {1'b0, a} - {1'b0, b};
      e.c = (a >= b);
      e.v = (a[63] != b[63]) && (f[63] != a[63]);
    end
    e.r = f[63:0];
    e.z = (e.r == 64'h0);
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CH = (g == 0) ? 16 : ((g == 1) ? 8 : 64);
    localparam int unsigned NC = 64 / CH;

    exp_t        exp_q[$];
    int unsigned t_q[$];
    int unsigned rd   = 0;
    bit          seen = 1'b0;

    multi_cycle_add_sub #(.WIDTH(64), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .sub       (sub_a[g]),
      .x         (x_a[g]),
      .y         (y_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .result    (result_a[g]),
      .cout      (cout_a[g]),
      .v         (v_a[g]),
      .zero      (zero_a[g])
    );

    // Record expectation at each accepted request.
    always @(posedge clk) begin
      if (rst_n && in_valid_a[g] && in_ready_a[g]) begin
        exp_q.push_back(model(x_a[g], y_a[g], sub_a[g]));
        t_q.push_back(cyc + 1);
      end
    end

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
      if (rnd_phase) begin
        #1;
        out_ready_a[g] = ($urandom_range(0, 3) != 0);
      end
    end

    // Monitor: compare every cycle the result is presented; drop on reset.
    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd   = exp_q.size();
        seen = 1'b0;
      end else if (out_valid_a[g]) begin
        if (rd >= exp_q.size()) begin
          total++;
          bad++;
          $display("FAIL d%0d spurious out_valid: got 1 want 0", g);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk($sformatf("d%0d latency", g), 64'(cyc - t_q[rd]), 64'(NC));
          end
          chk($sformatf("d%0d result", g), result_a[g], exp_q[rd].r);
          chk($sformatf("d%0d cout", g), 64'(cout_a[g]), 64'(exp_q[rd].c));
          chk($sformatf("d%0d v", g), 64'(v_a[g]), 64'(exp_q[rd].v));
          chk($sformatf("d%0d zero", g), 64'(zero_a[g]), 64'(exp_q[rd].z));
          chk($sformatf("d%0d in_ready busy", g), 64'(in_ready_a[g]), 64'h0);
          if (out_ready_a[g]) begin
            rd++;
            seen = 1'b0;
          end
        end
      end
      left_a[g] = exp_q.size() - rd;
    end
  end

  task automatic send(int idx, logic [63:0] a, logic [63:0] b, logic s);
    bit rdy;
    int unsigned n = 0;
    @(posedge clk);
    #1;
    in_valid_a[idx] = 1'b1;
    x_a[idx]        = a;
    y_a[idx]        = b;
    sub_a[idx]      = s;
    do begin
      @(negedge clk);
      rdy = in_ready_a[idx];
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    in_valid_a[idx] = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL d%0d accept timeout: in_ready stuck 0 want 1", idx);
    end
  endtask

  task automatic expect_out(string nm, logic [63:0] r, logic c, logic vv, logic z);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a[0] && n < 50);
    if (!out_valid_a[0]) begin
      total++;
      bad++;
      $display("FAIL %s timeout: out_valid 0 want 1", nm);
    end else begin
      chk({nm, " result"}, result_a[0], r);
      chk({nm, " cout"}, 64'(cout_a[0]), 64'(c));
      chk({nm, " v"}, 64'(v_a[0]), 64'(vv));
      chk({nm, " zero"}, 64'(zero_a[0]), 64'(z));
      if (out_ready_a[0]) begin
        @(negedge clk);
        chk({nm, " one-cycle valid"}, 64'(out_valid_a[0]), 64'h0);
      end
    end
  endtask

  task automatic chk_reset(string nm);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s d%0d in_ready", nm, i), 64'(in_ready_a[i]), 64'h1);
      chk($sformatf("%s d%0d out_valid", nm, i), 64'(out_valid_a[i]), 64'h0);
      chk($sformatf("%s d%0d result", nm, i), result_a[i], 64'h0);
      chk($sformatf("%s d%0d flags", nm, i),
          64'({cout_a[i], v_a[i], zero_a[i]}), 64'h0);
    end
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = 64'h0;
      2: r = 64'h8000_0000_0000_0000;
      3: r = 64'h7FFF_FFFF_FFFF_FFFF;
      4: r = 64'(r[15:0]);
      default: ;
    endcase
    return r;
  endfunction

  task automatic rand_ops(int idx, int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(idx, pick(), pick(), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_r;
    logic [63:0] snap;
    int unsigned n;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      sub_a[i]       = 1'b0;
      x_a[i]         = '0;
      y_a[i]         = '0;
      out_ready_a[i] = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on the CHUNK=16 instance.
    send(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    expect_out("add_ffff_1", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    expect_out("add_all1_1", 64'h0, 1'b1, 1'b0, 1'b1);
    send(0, 64'h8000_0000_0000_0000, 64'h1, 1'b1);
    expect_out("sub_min_1", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    send(0, 64'h5, 64'h7, 1'b1);
    expect_out("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Backpressure: result holds, new requests are refused until drained.
    @(posedge clk);
    #1 out_ready_a[0] = 1'b0;
    send(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    expect_out("bp_hold", 64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
    snap = 64'h2222_2222_2222_2211;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid_a[0] = ~in_valid_a[0];
      x_a[0]        = {$urandom, $urandom};
      y_a[0]        = {$urandom, $urandom};
      sub_a[0]      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp in_ready", 64'(in_ready_a[0]), 64'h0);
      chk("bp out_valid", 64'(out_valid_a[0]), 64'h1);
      chk("bp result", result_a[0], snap);
    end
    @(posedge clk);
    #1;
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    send(0, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b1);
    expect_out("bp_second", 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of RUN discards the operation.
    a_r = {$urandom, $urandom};
    send(0, a_r, 64'hFFFF_0000_FFFF_0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 64'h3, 64'h4, 1'b0);
    expect_out("after_reset", 64'h7, 1'b0, 1'b0, 1'b0);

    // Random traffic on all three chunk sizes concurrently.
    rnd_phase = 1'b1;
    fork
      rand_ops(0, 1000);
      rand_ops(1, 1000);
      rand_ops(2, 1000);
    join
    n = 0;
    while ((left_a[0] != 0 || left_a[1] != 0 || left_a[2] != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (left_a[0] != 0 || left_a[1] != 0 || left_a[2] != 0) begin
      total++;
      bad++;
      $display("FAIL drain timeout: pending %0d %0d %0d want 0",
               left_a[0], left_a[1], left_a[2]);
    end
    rnd_phase = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
